// File: rtl/dbus_periph_pkg.sv
// Shared types and register map for the data-bus UART transmitter.
package dbus_periph_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;

  localparam logic [1:0] UART_TXDATA  = 2'd0;
  localparam logic [1:0] UART_STATUS  = 2'd1;
  localparam logic [1:0] UART_CTRL    = 2'd2;
  localparam logic [1:0] UART_DIVISOR = 2'd3;

  localparam int STS_FULL    = 0;
  localparam int STS_EMPTY   = 1;
  localparam int STS_BUSY    = 2;
  localparam int STS_OVF     = 3;
  localparam int STS_CNT_LSB = 4;

  // start + 8 data + stop
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push is taken when full if a pop lands on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam logic [AW:0] ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = wp - rp;
  assign empty   = wp == rp;
  assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign rdata   = mem[rp[AW-1:0]];

  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + ONE;
      if (do_pop)  rp <= rp + ONE;
    end

  // When full, a same-edge push overwrites the slot being popped.
  always_ff @(posedge CLK)
    if (do_push) mem[wp[AW-1:0]] <= wdata;

endmodule

// File: rtl/dbus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: bus decode, register file, TX FIFO and bit-timed FSM.
module dbus_uart_tx
  import dbus_periph_pkg::*;
#(
  parameter logic [9:0] BASE_WADDR   = 10'h3F0,
  parameter int         FIFO_DEPTH   = 8,
  parameter int         CLKS_PER_BIT = 434
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [9:0]  daddr,
  input  logic [31:0] ddata_w,
  input  logic        d_w,
  input  logic        d_r,
  output logic [31:0] rdata,
  output logic        sel,
  output logic        tx,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    off;
  logic          wr, rd, push, pop, full, empty, last, n_tx;
  logic [CW-1:0] count;
  logic [7:0]    head, shreg, n_shreg;
  logic [15:0]   divisor, timer, n_timer;
  logic [2:0]    bitcnt, n_bitcnt;
  logic          enable, irq_en, overflow;
  uart_state_e   state, n_state;
  logic          unused_bits;

  assign sel  = daddr[9:2] == BASE_WADDR[9:2];
  assign off  = daddr[1:0];
  assign wr   = sel && d_w;
  assign rd   = sel && d_r;
  assign push = wr && off == UART_TXDATA;
  assign last = timer == 16'd0;
  assign unused_bits = ^ddata_w[31:16];

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK, .RSTn, .push, .pop,
    .wdata(ddata_w[7:0]), .rdata(head),
    .full, .empty, .count
  );

  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      enable   <= 1'b1;
      irq_en   <= 1'b0;
      divisor  <= 16'(CLKS_PER_BIT);
      overflow <= 1'b0;
    end else begin
      if (push && full && !pop)
        overflow <= 1'b1;
      else if (wr && off == UART_STATUS && ddata_w[STS_OVF])
        overflow <= 1'b0;
      if (wr && off == UART_CTRL) begin
        enable <= ddata_w[0];
        irq_en <= ddata_w[1];
      end
      if (wr && off == UART_DIVISOR)
        divisor <= (ddata_w[15:0] < 16'd2) ? 16'd2 : ddata_w[15:0];
    end

  always_comb begin
    rdata = '0;
    if (rd) begin
      case (off)
        UART_STATUS: begin
          rdata[STS_FULL]          = full;
          rdata[STS_EMPTY]         = empty;
          rdata[STS_BUSY]          = state != IDLE;
          rdata[STS_OVF]           = overflow;
          rdata[STS_CNT_LSB +: 4]  = 4'(count);
        end
        UART_CTRL:    rdata[1:0]  = {irq_en, enable};
        UART_DIVISOR: rdata[15:0] = divisor;
        default:      rdata       = '0;
      endcase
    end
  end

  always_comb begin
    n_state  = state;
    n_timer  = timer;
    n_bitcnt = bitcnt;
    n_shreg  = shreg;
    pop      = 1'b0;
    case (state)
      IDLE:
        if (enable && !empty) begin
          pop     = 1'b1;
          n_state = START;
          n_shreg = head;
          n_timer = divisor - 16'd1;
        end
      START:
        if (last) begin
          n_state  = DATA;
          n_bitcnt = 3'd0;
          n_timer  = divisor - 16'd1;
        end
      DATA:
        if (last) begin
          n_timer = divisor - 16'd1;
          if (bitcnt == 3'd7) n_state = STOP;
          else begin
            n_bitcnt = bitcnt + 3'd1;
            n_shreg  = shreg >> 1;
          end
        end
      STOP:
        if (last) begin
          // back-to-back frames: no idle gap when more data is queued
          if (enable && !empty) begin
            pop     = 1'b1;
            n_state = START;
            n_shreg = head;
            n_timer = divisor - 16'd1;
          end else n_state = IDLE;
        end
      default: n_state = IDLE;
    endcase
    if (!last && state != IDLE) n_timer = timer - 16'd1;
  end

  always_comb begin
    case (n_state)
      START:   n_tx = 1'b0;
      DATA:    n_tx = n_shreg[0];
      default: n_tx = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state  <= IDLE;
      timer  <= '0;
      bitcnt <= '0;
      shreg  <= '0;
      tx     <= 1'b1;
      irq    <= 1'b0;
    end else begin
      state  <= n_state;
      timer  <= n_timer;
      bitcnt <= n_bitcnt;
      shreg  <= n_shreg;
      tx     <= n_tx;
      irq    <= irq_en && empty && state == IDLE;
    end

endmodule

// File: tb/tb_dbus_uart_tx.sv
// Random + directed bench for dbus_uart_tx against a frame/queue-level reference model.
module tb_dbus_uart_tx;
  localparam logic [9:0] BASE  = 10'h3F0;
  localparam int         DEPTH = 8;
  localparam logic [9:0] A_TX  = BASE;
  localparam logic [9:0] A_STS = BASE + 10'd1;
  localparam logic [9:0] A_CTL = BASE + 10'd2;
  localparam logic [9:0] A_DIV = BASE + 10'd3;

  logic        CLK = 1'b0, RSTn;
  logic [9:0]  daddr;
  logic [31:0] ddata_w, rdata;
  logic        d_w, d_r, sel, tx, irq;

  dbus_uart_tx #(.BASE_WADDR(BASE), .FIFO_DEPTH(DEPTH), .CLKS_PER_BIT(434)) dut (
    .CLK(CLK), .RSTn(RSTn), .daddr(daddr), .ddata_w(ddata_w), .d_w(d_w), .d_r(d_r),
    .rdata(rdata), .sel(sel), .tx(tx), .irq(irq)
  );

  always #5 CLK = ~CLK;

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte queue plus the frame in flight as a 10-bit vector.
  byte unsigned q[$];
  bit       m_act, m_ovf, m_en, m_ien, m_irq, m_tx;
  bit [9:0] m_frame;
  int       m_bit, m_left, m_div;

  task automatic m_reset;
    q.delete();
    m_act = 0; m_ovf = 0; m_en = 1; m_ien = 0; m_irq = 0; m_tx = 1; m_div = 434;
    m_bit = 0; m_left = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [9:0] a, input logic r);
    logic [31:0] v;
    v = '0;
    if (r && a[9:2] == BASE[9:2]) begin
      case (a[1:0])
        2'd1: v = {24'd0, 4'(q.size()), m_ovf, m_act, q.size() == 0, q.size() == DEPTH};
        2'd2: v = {30'd0, m_ien, m_en};
        2'd3: v = {16'd0, 16'(m_div)};
        default: v = '0;
      endcase
    end
    return v;
  endfunction

  task automatic m_step(input logic w, input logic [9:0] a, input logic [31:0] d);
    int  c;
    bit  hit, start, popped, n_irq;
    byte unsigned b;
    c = q.size();
    hit = w && a[9:2] == BASE[9:2];
    n_irq = m_ien && c == 0 && !m_act;
    start = 0; popped = 0;
    if (m_act) begin
      m_left--;
      if (m_left == 0) begin
        m_bit++;
        if (m_bit == 10) begin
          m_act = 0;
          if (m_en && c > 0) start = 1;
        end else m_left = m_div;
      end
    end else if (m_en && c > 0) start = 1;
    if (start) begin
      b = q.pop_front();
      m_frame = {1'b1, b, 1'b0};
      m_bit = 0; m_left = m_div; m_act = 1; popped = 1;
    end
    if (hit) begin
      case (a[1:0])
        2'd0: if (c < DEPTH || popped) q.push_back(d[7:0]); else m_ovf = 1;
        2'd1: if (d[3]) m_ovf = 0;
        2'd2: begin m_en = d[0]; m_ien = d[1]; end
        default: m_div = (d[15:0] < 16'd2) ? 2 : int'(d[15:0]);
      endcase
    end
    m_tx  = m_act ? m_frame[m_bit] : 1'b1;
    m_irq = n_irq;
  endtask

  // One bus cycle: check registered outputs, drive, check combinational read path, clock.
  task automatic cyc(input logic w, input logic r, input logic [9:0] a, input logic [31:0] d);
    chk("tx", tx, m_tx);
    chk("irq", irq, m_irq);
    d_w = w; d_r = r; daddr = a; ddata_w = d;
    #1;
    chk("sel", sel, a[9:2] == BASE[9:2]);
    chk("rdata", rdata, m_read(a, r));
    @(posedge CLK);
    m_step(w, a, d);
    @(negedge CLK);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, A_STS, 32'd0);
  endtask

  task automatic reset_reads;
    for (int o = 0; o < 4; o++) begin
      d_w = 0; d_r = 1; daddr = BASE + 10'(o); ddata_w = '0;
      #1;
      chk("rst_rdata", rdata, m_read(daddr, 1'b1));
    end
    chk("rst_tx", tx, 1);
    chk("rst_irq", irq, 0);
  endtask

  initial begin
    RSTn = 0; d_w = 0; d_r = 0; daddr = '0; ddata_w = '0;
    m_reset();
    @(negedge CLK);
    reset_reads();
    @(negedge CLK);
    RSTn = 1;

    // single frame at DIVISOR=4
    cyc(1, 0, A_DIV, 32'd4);
    cyc(1, 0, A_TX, 32'hA5);
    idle(50);
    // back-to-back frames
    cyc(1, 0, A_TX, 32'h55);
    cyc(1, 0, A_TX, 32'h0F);
    idle(100);
    // overflow with transmitter disabled, then W1C
    cyc(1, 0, A_CTL, 32'd0);
    for (int i = 0; i < 9; i++) cyc(1, 0, A_TX, 32'(i + 8'h30));
    idle(3);
    cyc(1, 0, A_STS, 32'h8);
    idle(3);
    // full FIFO draining while pushes keep arriving
    cyc(1, 0, A_DIV, 32'd1);
    cyc(1, 0, A_CTL, 32'd1);
    for (int i = 0; i < 120; i++) cyc(1, i[0], i[0] ? A_STS : A_TX, $urandom);
    idle(300);
    // irq after drain, dropped by a push
    cyc(1, 0, A_CTL, 32'd3);
    cyc(1, 0, A_TX, 32'hC3);
    idle(40);
    cyc(1, 0, A_TX, 32'h3C);
    idle(40);

    for (int i = 0; i < 3000; i++) begin
      logic w, r;
      logic [9:0] a;
      logic [31:0] d;
      w = $urandom_range(0, 99) < 45;
      r = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0: a = 10'($urandom);
        1: a = A_STS;
        2: a = A_CTL;
        3: a = A_DIV;
        default: a = A_TX;
      endcase
      d = $urandom;
      if (a == A_CTL && $urandom_range(0, 9) != 0) d[0] = 1'b1;
      if (a == A_DIV) d[15:0] = 16'($urandom_range(0, 6));
      cyc(w, r, a, d);
    end

    // reset in the middle of data bit 3
    idle(200);
    cyc(1, 0, A_CTL, 32'd1);
    cyc(1, 0, A_DIV, 32'd4);
    cyc(1, 0, A_TX, 32'hA5);
    cyc(1, 0, A_TX, 32'h3C);
    idle(18);
    chk("mid_tx", tx, m_tx);
    #2 RSTn = 0;
    #1 chk("async_tx", tx, 1);
    m_reset();
    reset_reads();
    @(negedge CLK);
    RSTn = 1;
    idle(60);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
